cflog_drain: RTL and testbench
==============================

Name: cflog_drain

Overview:
- Reader end of the CFLog written by the control-flow logging hardware.
- When a flush is requested, cflog_drain reads the logged 16-bit words from log memory in order: index 0 up to the write pointer minus 1.
- It streams a length header, then the words, over a valid/ready interface to the attestation transport (UART/packetiser).
- It then pulses a clear so the writer restarts at pointer 0.

Parameters:
- LOG_SIZE, 16'h0100, log capacity in 2-byte words; the drain length is clamped to this.
- LOG_BASE, 16'h0000, byte address of log word 0 in memory.

Ports:
- clk  in  1  system clock.
- puc  in  1  asynchronous, active-high reset.
- flush  in  1  start request; sampled only in IDLE.
- cflow_log_ptr  in  16  writer pointer (number of words logged).
- cflow_hw_wen  in  1  writer write strobe; used for overrun detection.
- mem_ren  out  1  log memory read enable.
- mem_addr  out  16  byte address to read.
- mem_rdata  in  16  read data, valid exactly 1 cycle after mem_ren.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  16  stream word.
- out_last  out  1  marks the final word of the transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- log_clear  out  1  one-cycle pulse, coincident with done; writer resets its pointer.
- overrun  out  1  sticky flag: the writer wrote during a transfer.

Behaviour:
- Reset (puc high, asynchronous, any state, including mid-transfer):
  - state goes to IDLE.
  - All outputs are 0, including out_data and mem_addr.
  - Internal len_q, idx and data_q are cleared.
  - No done or log_clear pulse is issued for an aborted transfer.
- Registers: len_q[15:0] (words to send), idx[15:0] (current word index), data_q[15:0] (captured read data).
- IDLE:
  - busy=0.
  - If flush=1: len_q <= (cflow_log_ptr > LOG_SIZE) ? LOG_SIZE : cflow_log_ptr; idx <= 0; overrun <= 0; next state HDR.
  - flush asserted outside IDLE is ignored. A flush held high after DONE starts a new transfer.
- HDR:
  - out_valid=1, out_data=len_q, out_last=(len_q==0).
  - On out_valid & out_ready: if len_q==0 go to DONE, else go to RD.
- RD:
  - mem_ren=1 for one cycle, mem_addr=LOG_BASE + {idx[14:0],1'b0}. The addition wraps modulo 2^16.
  - Next state LAT.
- LAT: data_q <= mem_rdata; next state SEND.
- SEND:
  - out_valid=1, out_data=data_q, out_last=(idx==len_q-1).
  - On handshake: idx <= idx+1. If out_last, go to DONE; else go to RD.
- DONE: done=1 and log_clear=1 for exactly one cycle; next state IDLE.
- busy:
  - busy=1 in every state except IDLE.
  - busy goes high the cycle after flush is sampled and drops the cycle after DONE.
- Stream rules:
  - out_valid, once asserted, stays high with out_data and out_last stable until out_ready.
  - out_valid is 0 in IDLE, RD, LAT and DONE.
  - Back-pressure of any length is legal.
- Throughput: 3 cycles per data word when out_ready=1 continuously.
  - Total cycles from flush sampled to done pulse = 2 + 3*len_q (header 1, DONE 1).
- Overrun: if cflow_hw_wen=1 in any cycle while busy=1, overrun <= 1. It holds until the next flush acceptance.
  - Already-latched len_q is not changed by writer activity.
- Simultaneous events:
  - puc dominates all.
  - flush on the same cycle as DONE is not accepted; it is accepted on the following IDLE cycle.
- cflow_log_ptr is sampled only at flush acceptance; later changes have no effect.

Test Plan:
- Basic 3-word drain:
  - Stimulus: memory at LOG_BASE holds 16'hE010, 16'hE020, 16'hE030; cflow_log_ptr=3; out_ready=1; pulse flush.
  - Response: stream 3, E010, E020, E030. out_last only on E030. mem_addr sequence 0000, 0002, 0004. done/log_clear pulse at cycle 11 after flush acceptance. busy falls next cycle.
- Empty log:
  - Stimulus: cflow_log_ptr=0, flush.
  - Response: a single header word 0 with out_last=1, no mem_ren ever, done on the cycle after the handshake.
- Clamp:
  - Stimulus: LOG_SIZE=4, cflow_log_ptr=16'h0009.
  - Response: header 4, exactly 4 data words, last mem_addr = LOG_BASE+6.
- Back-pressure:
  - Stimulus: out_ready low for 5 cycles during the second data word.
  - Response: out_valid held and out_data stable throughout, no extra mem_ren, correct order after release.
- Reset mid-transfer:
  - Stimulus: assert puc asynchronously (between clock edges) while in SEND of word 1 of 3.
  - Response: all outputs 0 immediately, no done/log_clear pulse. A subsequent flush restarts from idx 0 with header 3.
- Overrun and flush-while-busy:
  - Stimulus: pulse cflow_hw_wen during a transfer and reassert flush mid-transfer.
  - Response: overrun=1 is held after done. The second flush is ignored. overrun clears to 0 when the next flush is accepted in IDLE.

Source files
------------

// File: rtl/cflog_drain.sv
// CFLog reader: on flush, streams a length header followed by the logged words over valid/ready,
// then pulses done/log_clear so the writer restarts at pointer 0.
module cflog_drain #(
  parameter logic [15:0] LOG_SIZE = 16'h0100,
  parameter logic [15:0] LOG_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        puc,
  input  logic        flush,
  input  logic [15:0] cflow_log_ptr,
  input  logic        cflow_hw_wen,
  output logic        mem_ren,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        log_clear,
  output logic        overrun
);

  typedef enum logic [2:0] {StIdle, StHdr, StRd, StLat, StSend, StDone} state_e;

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [15:0] data_q;
  logic [15:0] clamp_len;

  assign clamp_len = (cflow_log_ptr > LOG_SIZE) ? LOG_SIZE : cflow_log_ptr;

  // Read port and stream data are pure decodes of registered state, so they are 0 in reset.
  assign mem_ren  = (state_q == StRd);
  assign mem_addr = (state_q == StRd) ? (LOG_BASE + {idx_q[14:0], 1'b0}) : 16'h0000;

  always_comb begin
    out_data = 16'h0000;
    case (state_q)
      StHdr:   out_data = len_q;
      StSend:  out_data = data_q;
      default: out_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge puc) begin
    if (puc) begin
      state_q   <= StIdle;
      len_q     <= 16'h0000;
      idx_q     <= 16'h0000;
      data_q    <= 16'h0000;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      log_clear <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      log_clear <= 1'b0;
      if (busy && cflow_hw_wen) overrun <= 1'b1;

      case (state_q)
        StIdle: begin
          if (flush) begin
            len_q     <= clamp_len;
            idx_q     <= 16'h0000;
            overrun   <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_last  <= (clamp_len == 16'h0000);
            state_q   <= StHdr;
          end
        end
        StHdr: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (len_q == 16'h0000) begin
              done      <= 1'b1;
              log_clear <= 1'b1;
              state_q   <= StDone;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: state_q <= StLat;
        StLat: begin
          // Read data is only valid in this cycle; capture it and present it next.
          data_q    <= mem_rdata;
          out_valid <= 1'b1;
          out_last  <= (idx_q == len_q - 16'd1);
          state_q   <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            idx_q     <= idx_q + 16'd1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              done      <= 1'b1;
              log_clear <= 1'b1;
              state_q   <= StDone;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cflog_drain.sv
// Randomized self-checking bench for cflog_drain against a transaction-level model
// (expected word queue, read address sequence, cycle budget 2+3*len+stalls).
module tb_cflog_drain;

  localparam logic [15:0] LSIZE = 16'h0004;
  localparam logic [15:0] LBASE = 16'h0000;

  logic        clk = 1'b0;
  logic        puc = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] cflow_log_ptr = 16'h0000;
  logic        cflow_hw_wen = 1'b0;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        log_clear;
  logic        overrun;

  logic [15:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  cflog_drain #(.LOG_SIZE(LSIZE), .LOG_BASE(LBASE)) dut (
    .clk(clk), .puc(puc), .flush(flush), .cflow_log_ptr(cflow_log_ptr),
    .cflow_hw_wen(cflow_hw_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .log_clear(log_clear), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Read data valid exactly one cycle after mem_ren; garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_addr[7:1]] : 16'($urandom);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_data"}, out_data, 0);
    check_eq({tag, "_last"}, out_last, 0);
    check_eq({tag, "_ren"}, mem_ren, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_clear"}, log_clear, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
  endtask

  // mode 0: ready=1; 1: random ready/flush/wen/ptr; 2: 5-cycle stall on 2nd data word;
  // 3: ready=1, wen pulse mid-transfer, flush mid-transfer and on the done cycle.
  task automatic do_xfer(input logic [15:0] ptr, input int mode);
    int len, hs, rd, stalls, bp, dn;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w, prev_data;
    bit ov, prev_stall, prev_last, seen;
    len = (ptr > LSIZE) ? int'(LSIZE) : int'(ptr);
    dn = 2 + 3 * len;
    exp_q = {};
    exp_q.push_back(16'(len));
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(int'(LBASE) / 2 + i) % 128]);

    @(negedge clk);
    flush = 1'b1;
    cflow_log_ptr = ptr;
    cflow_hw_wen = 1'b0;
    out_ready = 1'b1;
    #1 check_eq("idle_busy", busy, 0);

    ov = 0; hs = 0; rd = 0; stalls = 0; bp = 0; prev_stall = 0; seen = 0;
    prev_data = 16'h0; prev_last = 0;
    for (int n = 1; n <= 400 && !seen; n++) begin
      @(negedge clk);
      cflow_log_ptr = 16'($urandom);
      case (mode)
        1: begin
          out_ready = ($urandom_range(0, 3) != 0);
          flush = 1'($urandom_range(0, 1));
          cflow_hw_wen = ($urandom_range(0, 7) == 0);
        end
        2: begin
          out_ready = !(hs == 2 && bp < 5);
          flush = 1'b0;
          cflow_hw_wen = 1'b0;
        end
        3: begin
          out_ready = 1'b1;
          flush = (n == 4) || (n == dn);
          cflow_hw_wen = (n == 3);
        end
        default: begin
          out_ready = 1'b1;
          flush = 1'b0;
          cflow_hw_wen = 1'b0;
        end
      endcase
      #1;
      check_eq("busy", busy, 1);
      check_eq("overrun", overrun, ov);
      if (cflow_hw_wen) ov = 1;
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_last", out_last, prev_last);
      end
      if (mem_ren) begin
        check_eq("rd_addr", mem_addr, LBASE + 16'(2 * rd));
        rd++;
      end
      if (out_valid && out_ready) begin
        check_eq("word_in_range", hs < len + 1, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check_eq("word_data", out_data, exp_w);
          check_eq("word_last", out_last, exp_q.size() == 0);
        end
        hs++;
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        stalls++;
        if (hs == 2) bp++;
      end
      prev_data = out_data;
      prev_last = out_last;
      if (done) begin
        seen = 1;
        check_eq("log_clear", log_clear, 1);
        check_eq("done_cycle", n, dn + stalls);
        check_eq("words", hs, len + 1);
        check_eq("reads", rd, len);
      end else begin
        check_eq("clear_early", log_clear, 0);
      end
    end
    check_eq("done_seen", seen, 1);
    if (mode == 2) check_eq("bp_cycles", bp, (len >= 2) ? 5 : 0);
    if (mode == 3) check_eq("ov_expected", ov, 1);

    @(negedge clk);
    flush = 1'b0;
    cflow_hw_wen = 1'b1;
    #1;
    check_eq("busy_after", busy, 0);
    check_eq("done_after", done, 0);
    check_eq("ov_after", overrun, ov);
    @(negedge clk);
    cflow_hw_wen = 1'b0;
    #1 check_eq("ov_idle_hold", overrun, ov);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    puc = 1'b0;
    #1 check_all_zero("post_reset");

    // Basic 3-word drain
    mem[0] = 16'hE010; mem[1] = 16'hE020; mem[2] = 16'hE030;
    do_xfer(16'd3, 0);
    // Empty log
    do_xfer(16'd0, 0);
    // Clamp to LOG_SIZE
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    do_xfer(16'h0009, 0);
    // Back-pressure on the second data word
    do_xfer(16'd3, 2);
    // Overrun, flush while busy and on the done cycle, then overrun clears on next accept
    do_xfer(16'd4, 3);
    do_xfer(16'd2, 0);

    // Reset mid-transfer, in SEND of word 1 of 3
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    flush = 1'b1; cflow_log_ptr = 16'd3; out_ready = 1'b1; cflow_hw_wen = 1'b0;
    @(negedge clk);
    flush = 1'b0; cflow_hw_wen = 1'b1;
    @(negedge clk);
    cflow_hw_wen = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_eq("pre_rst_valid", out_valid, 1);
    check_eq("pre_rst_data", out_data, mem[1]);
    check_eq("pre_rst_ov", overrun, 1);
    #2 puc = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    #1 check_all_zero("mid_reset_held");
    @(negedge clk);
    puc = 1'b0;
    do_xfer(16'd3, 0);

    // Randomized transfers
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      do_xfer(16'($urandom_range(0, 9)), ($urandom_range(0, 2) == 0) ? 3 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
